sb_tx_rdi_encoder: RTL and testbench

Transmit-side sideband encoder for RDI messages. It accepts compact RDI message requests (code, sub-code, info) from the PHY link-training and state logic, queues them, and builds 64-bit UCIe "message without data" sideband headers. It presents each header to the sideband TX framer over a valid/ready handshake. Its field placement and info rules mirror the RX RDI decoder, so a header it produces decodes back to the original request.

---
 rtl/sb_tx_rdi_encoder.sv | 120 ++++++++++++
 tb/tb_sb_tx_rdi_encoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sb_tx_rdi_encoder.sv
// Transmit-side RDI sideband encoder: queues compact RDI requests and emits
// 64-bit message-without-data headers over a valid/ready handshake.
module sb_tx_rdi_encoder #(
  parameter int         DEPTH  = 2,
  parameter logic [2:0] SRC_ID = 3'b010,
  parameter logic [2:0] DST_ID = 3'b110
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rdi_msg,
  input  logic [1:0]  i_rdi_msg_code,
  input  logic [3:0]  i_rdi_msg_sub_code,
  input  logic [1:0]  i_rdi_msg_info,
  output logic        o_rdi_ready,
  output logic [63:0] o_rdi_header,
  output logic        o_rdi_header_valid,
  input  logic        i_rdi_header_ready,
  output logic        o_rdi_err,
  output logic        o_rdi_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Queue entry layout: {code[1:0], sub_code[3:0], info[1:0]}
  logic [7:0]    mem [DEPTH];
  logic [7:0]    req_entry;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   header_q, header_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          accept, legal, out_free, q_empty, pop, push, bypass;

  function automatic logic [63:0] encode(input logic [7:0] e);
    logic [63:0] h;
    logic [1:0]  code;
    h       = '0;
    code    = e[7:6];
    h[4:0]  = 5'b10010;
    h[21:14] = {6'b0, code};
    h[31:29] = SRC_ID;
    h[39:32] = {4'b0, e[5:2]};
    case (code)
      2'd0:    h[55:40] = {14'b0, e[1:0]};
      2'd2:    h[55:40] = {15'b0, e[0]};
      default: h[55:40] = 16'h0000;
    endcase
    h[58:56] = DST_ID;
    h[62]    = ^h[61:0];
    return h;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign req_entry   = {i_rdi_msg_code, i_rdi_msg_sub_code, i_rdi_msg_info};
  assign o_rdi_ready = (cnt_q != FULL_CNT);

  always_comb begin
    q_empty  = (cnt_q == '0);
    out_free = !valid_q || i_rdi_header_ready;
    accept   = i_rdi_msg && o_rdi_ready;
    legal    = (i_rdi_msg_code != 2'd3);
    pop      = !q_empty && out_free;
    // An empty queue with a free output register lets a request skip the queue.
    bypass   = accept && legal && q_empty && out_free;
    push     = accept && legal && !bypass;
    err_d    = accept && !legal;

    header_d = header_q;
    valid_d  = valid_q;
    if (pop) begin
      header_d = encode(mem[rd_ptr_q]);
      valid_d  = 1'b1;
    end else if (bypass) begin
      header_d = encode(req_entry);
      valid_d  = 1'b1;
    end else if (valid_q && i_rdi_header_ready) begin
      valid_d  = 1'b0;
    end

    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= req_entry;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      header_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      header_q <= header_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign o_rdi_header       = header_q;
  assign o_rdi_header_valid = valid_q;
  assign o_rdi_err          = err_q;
  assign o_rdi_busy         = (cnt_q != '0) || valid_q;

endmodule

// File: tb/tb_sb_tx_rdi_encoder.sv
// Self-checking bench for sb_tx_rdi_encoder: directed scenarios plus random
// traffic against an ordered list of outstanding requests.
module tb_sb_tx_rdi_encoder;

  localparam int         DEPTH  = 2;
  localparam logic [2:0] SRC_ID = 3'b010;
  localparam logic [2:0] DST_ID = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg = 1'b0;
  logic [1:0]  code = '0;
  logic [3:0]  sub = '0;
  logic [1:0]  info = '0;
  logic        hrdy = 1'b0;
  logic        rdy, hvalid, err, busy;
  logic [63:0] header;

  int checks = 0;
  int failures = 0;

  // Accepted legal requests not yet consumed by the framer, oldest first.
  logic [7:0] pend[$];
  logic       err_exp = 1'b0;

  sb_tx_rdi_encoder #(.DEPTH(DEPTH), .SRC_ID(SRC_ID), .DST_ID(DST_ID)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_rdi_msg          (msg),
    .i_rdi_msg_code     (code),
    .i_rdi_msg_sub_code (sub),
    .i_rdi_msg_info     (info),
    .o_rdi_ready        (rdy),
    .o_rdi_header       (header),
    .o_rdi_header_valid (hvalid),
    .i_rdi_header_ready (hrdy),
    .o_rdi_err          (err),
    .o_rdi_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] info_rule(input logic [1:0] c, input logic [1:0] i);
    if (c == 2'd0) return 16'(i);
    if (c == 2'd2) return 16'(i & 2'b01);
    return 16'h0;
  endfunction

  function automatic logic [63:0] model_hdr(input logic [7:0] e);
    logic [63:0] h;
    h = 64'h12
      + (64'(e[7:6]) << 14)
      + (64'(SRC_ID) << 29)
      + (64'(e[5:2]) << 32)
      + (64'(info_rule(e[7:6], e[1:0])) << 40)
      + (64'(DST_ID) << 56);
    if ($countones(h) % 2 == 1) h = h + (64'd1 << 62);
    return h;
  endfunction

  // Called at a falling edge: checks outputs, drives inputs, advances the model.
  task automatic step(input logic m, input logic [1:0] c, input logic [3:0] s,
                      input logic [1:0] i, input logic hr);
    logic exp_rdy;
    exp_rdy = (pend.size() < DEPTH + 1);
    check_eq("ready", 64'(rdy), 64'(exp_rdy));
    check_eq("valid", 64'(hvalid), 64'(pend.size() != 0));
    check_eq("busy", 64'(busy), 64'(pend.size() != 0));
    check_eq("err", 64'(err), 64'(err_exp));
    if (pend.size() != 0) begin
      check_eq("header", header, model_hdr(pend[0]));
      check_eq("dec_code", 64'(header[21:14]), 64'(pend[0][7:6]));
      check_eq("dec_sub", 64'(header[39:32]), 64'(pend[0][5:2]));
      check_eq("dec_info", 64'(header[55:40]), 64'(info_rule(pend[0][7:6], pend[0][1:0])));
      check_eq("parity", 64'($countones(header) % 2), 64'd0);
    end
    msg = m; code = c; sub = s; info = i; hrdy = hr;
    if (pend.size() != 0 && hr) void'(pend.pop_front());
    err_exp = 1'b0;
    if (m && exp_rdy) begin
      if (c == 2'd3) err_exp = 1'b1;
      else pend.push_back({c, s, i});
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_header"}, header, 64'h0);
    check_eq({tag, "_valid"}, 64'(hvalid), 64'd0);
    check_eq({tag, "_err"}, 64'(err), 64'd0);
    check_eq({tag, "_ready"}, 64'(rdy), 64'd1);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Basic encodings: Req, Nop, Resp.
    step(1, 2'd1, 4'h3, 2'b11, 1);
    step(1, 2'd0, 4'h5, 2'b10, 1);
    step(1, 2'd2, 4'h1, 2'b11, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Fill: one in output, DEPTH queued, 4th and an illegal one ignored.
    step(1, 2'd1, 4'hA, 2'b01, 0);
    step(1, 2'd0, 4'hB, 2'b11, 0);
    step(1, 2'd2, 4'hC, 2'b01, 0);
    step(1, 2'd0, 4'hD, 2'b00, 0);
    step(1, 2'd3, 4'hE, 2'b00, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Illegal codes: single and back-to-back.
    step(1, 2'd3, 4'h2, 2'b01, 1);
    step(0, 0, 0, 0, 1);
    step(1, 2'd3, 4'h0, 2'b00, 1);
    step(1, 2'd3, 4'h1, 2'b00, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Asynchronous reset with headers pending.
    step(1, 2'd1, 4'h1, 2'b00, 0);
    step(1, 2'd2, 4'h2, 2'b01, 0);
    step(1, 2'd0, 4'h3, 2'b10, 0);
    msg = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    pend.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);

    // Loopback sweep over every legal code, sub-code and info value.
    for (int c = 0; c < 3; c++)
      for (int s = 0; s < 16; s++)
        for (int i = 0; i < 4; i++)
          step(1, 2'(c), 4'(s), 2'(i), 1);
    step(0, 0, 0, 0, 1);

    // Random traffic with random backpressure.
    for (int n = 0; n < 2000; n++)
      step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 4'($urandom),
           2'($urandom), $urandom_range(0, 3) != 0);
    for (int n = 0; n < DEPTH + 3; n++) step(0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
